// File: rtl/bp_be_fe_queue_ckpt_if.sv
// Handshake bundle between the FE/BE and the checkpointed fe_queue.
// The FE/BE side drives the master modport and the queue implements the slave modport.
interface bp_be_fe_queue_ckpt_if #(
  parameter int width_p = 128
);
  logic [width_p-1:0] fe_queue_i;
  logic               fe_queue_v_i;
  logic               fe_queue_ready_o;
  logic [width_p-1:0] fe_queue_o;
  logic               fe_queue_v_o;
  logic               fe_queue_yumi_i;
  logic               fe_queue_deq_i;
  logic               fe_queue_roll_i;
  logic               fe_queue_clr_i;

  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
           fe_queue_deq_i, fe_queue_roll_i, fe_queue_clr_i,
    input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o
  );

  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
           fe_queue_deq_i, fe_queue_roll_i, fe_queue_clr_i,
    output fe_queue_ready_o, fe_queue_o, fe_queue_v_o
  );
endinterface

// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointed FIFO between FE and BE.
// The FE enqueues packets. The BE reads them speculatively (yumi), commits them (deq),
// replays from the commit point (roll) or flushes everything (clr).
// Pointers carry one extra wrap bit. Full and empty are therefore exact across unlimited wraps.
module bp_be_fe_queue_ckpt #(
  parameter int els_p   = 8,
  parameter int width_p = 128
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bp_be_fe_queue_ckpt_if.slave  q_if
);

  localparam int idx_width_lp = $clog2(els_p);
  localparam int ptr_width_lp = idx_width_lp + 1;
  localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);
  localparam logic [ptr_width_lp-1:0] ptr_els_lp = ptr_width_lp'(els_p);

  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] cptr_q, cptr_d;
  logic [width_p-1:0]      mem_q [els_p];
  logic                    mem_we;
  logic [ptr_width_lp-1:0] occupancy;
  logic                    full;
  logic                    enq_fire;

  // Status is derived from registered pointers only, so inputs never reach outputs combinationally.
  assign occupancy = wptr_q - cptr_q;
  assign full      = (occupancy == ptr_els_lp);
  assign enq_fire  = q_if.fe_queue_v_i & ~full;

  assign q_if.fe_queue_ready_o = ~full;
  assign q_if.fe_queue_v_o     = (rptr_q != wptr_q);
  assign q_if.fe_queue_o       = mem_q[rptr_q[idx_width_lp-1:0]];

  // Next-pointer logic with priority clr > roll > {yumi, deq, enq}.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held, which avoids inferred latches.
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    mem_we = 1'b0;
    if (q_if.fe_queue_clr_i) begin
      // A concurrent enqueue is handshaken but dropped, so wptr stays where it is.
      rptr_d = wptr_q;
      cptr_d = wptr_q;
    end else begin
      if (enq_fire) begin
        wptr_d = wptr_q + ptr_one_lp;
        mem_we = 1'b1;
      end
      if (q_if.fe_queue_deq_i) begin
        cptr_d = cptr_q + ptr_one_lp;
      end
      // Roll returns to the commit point after any same-cycle commit has been applied.
      if (q_if.fe_queue_roll_i) begin
        rptr_d = cptr_d;
      end else if (q_if.fe_queue_yumi_i) begin
        rptr_d = rptr_q + ptr_one_lp;
      end
    end
  end

  // Pointer registers; an asynchronous reset empties the queue immediately.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Packet storage, written at the enqueue pointer.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; empty pointers already mask stale contents.
    if (mem_we) begin
      mem_q[wptr_q[idx_width_lp-1:0]] <= q_if.fe_queue_i;
    end
  end

  // Protocol checks for the BE side. They are ignored where clr or roll discards the event.
  a_yumi_when_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(q_if.fe_queue_yumi_i && !q_if.fe_queue_v_o && !q_if.fe_queue_clr_i && !q_if.fe_queue_roll_i))
    else $error("yumi asserted with no valid packet");

  a_deq_nothing_read: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(q_if.fe_queue_deq_i && (cptr_q == rptr_q) && !q_if.fe_queue_clr_i))
    else $error("deq asserted with no read-but-uncommitted packet");

  a_occupancy_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    occupancy <= ptr_els_lp)
    else $error("occupancy exceeds queue depth");

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// Self-checking bench for bp_be_fe_queue_ckpt.
// It applies directed vectors, corner sequences, and random traffic against a queue-based model.
module tb_bp_be_fe_queue_ckpt;

  localparam int els_p   = 8;
  localparam int width_p = 128;

  logic clk_i;
  logic reset_n_i;

  bp_be_fe_queue_ckpt_if #(.width_p(width_p)) q_if ();

  bp_be_fe_queue_ckpt #(.els_p(els_p), .width_p(width_p)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .q_if      (q_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         v;
    logic [7:0]   data;
    logic         yumi;
    logic         deq;
    logic         roll;
    logic         clr;
    logic         exp_ready;
    logic         exp_v;
    logic [7:0]   exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [width_p-1:0] act, input logic [width_p-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [width_p-1:0] data, input logic yumi,
                       input logic deq, input logic roll, input logic clr);
    q_if.fe_queue_v_i    = v;
    q_if.fe_queue_i      = data;
    q_if.fe_queue_yumi_i = yumi;
    q_if.fe_queue_deq_i  = deq;
    q_if.fe_queue_roll_i = roll;
    q_if.fe_queue_clr_i  = clr;
  endtask

  // Apply the driven inputs for one rising edge, then let the outputs settle.
  task automatic step();
    @(posedge clk_i);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add(input logic v, input logic [7:0] data, input logic yumi, input logic deq,
                     input logic roll, input logic clr, input logic er, input logic ev,
                     input logic [7:0] ed);
    vec_t r;
    r.v = v; r.data = data; r.yumi = yumi; r.deq = deq; r.roll = roll; r.clr = clr;
    r.exp_ready = er; r.exp_v = ev; r.exp_data = ed;
    vecs.push_back(r);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Packet model: entries from the commit point to the write point, plus the read offset into them.
    logic [width_p-1:0] mq[$];
    int                 rd;

    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n_i = 1'b0;
    #12;
    check("reset_ready", q_if.fe_queue_ready_o, 1'b1);
    check("reset_v", q_if.fe_queue_v_o, 1'b0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // ---------------- directed vector table ----------------
    // Fill to full; the 9th packet is held off.
    for (int k = 1; k <= 8; k++) add(1, 8'(k), 0, 0, 0, 0, (k < 8), 1, 8'h01);
    add(1, 8'h09, 0, 0, 0, 0, 0, 1, 8'h01);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00);
    // Roll: 4 enqueued, 3 read, 1 committed, replay from the commit point.
    for (int k = 0; k < 4; k++) add(1, 8'h10 + 8'(k), 0, 0, 0, 0, 1, 1, 8'h10);
    add(0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h11);
    add(0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h12);
    add(0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h13);
    add(0, 8'h00, 0, 1, 0, 0, 1, 1, 8'h13);
    add(0, 8'h00, 0, 0, 1, 0, 1, 1, 8'h11);
    // An occupancy of 3 leaves room for exactly 5 more packets.
    for (int k = 0; k < 5; k++) add(1, 8'h14 + 8'(k), 0, 0, 0, 0, (k < 4), 1, 8'h11);
    // Read 2 more, then deq and roll together, with the commit applied before the roll.
    add(0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h12);
    add(0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h13);
    add(0, 8'h00, 0, 1, 1, 0, 1, 1, 8'h12);
    // Full with a simultaneous deq and enqueue: the enqueue is refused and ready rises afterwards.
    add(1, 8'h19, 0, 0, 0, 0, 0, 1, 8'h12);
    add(0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h13);
    add(1, 8'h1A, 0, 1, 0, 0, 1, 1, 8'h13);
    add(1, 8'h1A, 0, 0, 0, 0, 0, 1, 8'h13);
    add(0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, width_p'(vecs[i].data), vecs[i].yumi, vecs[i].deq, vecs[i].roll, vecs[i].clr);
      step();
      check($sformatf("vec%0d_ready", i), q_if.fe_queue_ready_o, vecs[i].exp_ready);
      check($sformatf("vec%0d_v", i), q_if.fe_queue_v_o, vecs[i].exp_v);
      if (vecs[i].exp_v) check($sformatf("vec%0d_data", i), q_if.fe_queue_o, width_p'(vecs[i].exp_data));
    end

    // ---------------- stream across two wraps ----------------
    begin
      int sent = 0, got = 0, committed = 0;
      for (int cyc = 0; cyc < 40 && committed < 16; cyc++) begin
        logic yumi, deq, acc;
        yumi = q_if.fe_queue_v_o;
        deq  = (got > committed);
        acc  = (sent < 16) && q_if.fe_queue_ready_o;
        if (yumi) check("stream_data", q_if.fe_queue_o, width_p'(8'hA0 + 8'(got)));
        drive(sent < 16, width_p'(8'hA0 + 8'(sent)), yumi, deq, 1'b0, 1'b0);
        step();
        if (acc) sent++;
        if (yumi) got++;
        if (deq) committed++;
        check("stream_ready", q_if.fe_queue_ready_o, 1'b1);
      end
      check("stream_count", 32'(committed), 32'd16);
      check("stream_empty", q_if.fe_queue_v_o, 1'b0);
    end

    // ---------------- clr with a concurrent enqueue ----------------
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, width_p'(8'h20 + 8'(k)), 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0); step();
    check("clr_pre_data", q_if.fe_queue_o, width_p'(8'h22));
    drive(1'b1, width_p'(8'hFF), 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("clr_v", q_if.fe_queue_v_o, 1'b0);
    check("clr_ready", q_if.fe_queue_ready_o, 1'b1);
    step();
    step();
    check("clr_still_empty", q_if.fe_queue_v_o, 1'b0);
    drive(1'b1, width_p'(8'h30), 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("clr_after_v", q_if.fe_queue_v_o, 1'b1);
    check("clr_after_data", q_if.fe_queue_o, width_p'(8'h30));

    // ---------------- asynchronous reset between edges ----------------
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, width_p'(8'h40 + 8'(k)), 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    check("areset_pre_ready", q_if.fe_queue_ready_o, 1'b0);
    #3;
    reset_n_i = 1'b0;
    #1;
    check("areset_v", q_if.fe_queue_v_o, 1'b0);
    check("areset_ready", q_if.fe_queue_ready_o, 1'b1);
    #2;
    reset_n_i = 1'b1;
    step();
    check("areset_after_v", q_if.fe_queue_v_o, 1'b0);

    // ---------------- random traffic against the model ----------------
    mq.delete();
    rd = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic               v, yumi, deq, roll, clr, ready_e;
      logic [width_p-1:0] data;
      ready_e = (mq.size() < els_p);
      v    = ($urandom_range(3) != 0);
      data = {$urandom, $urandom, $urandom, $urandom};
      clr  = ($urandom_range(40) == 0);
      roll = ($urandom_range(15) == 0);
      yumi = (rd < mq.size()) && ($urandom_range(1) == 1);
      deq  = (rd > 0) && ($urandom_range(2) == 0);
      drive(v, data, yumi, deq, roll, clr);
      step();
      if (clr) begin
        mq.delete();
        rd = 0;
      end else begin
        if (deq) begin
          void'(mq.pop_front());
          rd--;
        end
        if (roll) rd = 0;
        else if (yumi) rd++;
        if (v && ready_e) mq.push_back(data);
      end
      check("rand_ready", q_if.fe_queue_ready_o, (mq.size() < els_p));
      check("rand_v", q_if.fe_queue_v_o, (rd < mq.size()));
      if (rd < mq.size()) check("rand_data", q_if.fe_queue_o, mq[rd]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
